// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART transmit path.
//   tx_state_t      : transmitter FSM state (IDLE, START, DATA, STOP)
//   UART_DATA_BITS  : payload bits per frame (8N1)
//   UART_FRAME_BITS : start + data + stop bits per frame
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam int UART_DATA_BITS  = 8;
   localparam int UART_FRAME_BITS = 10;

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with an occupancy counter.
// Ports:
//   clk, reset       : rising-edge clock, asynchronous active-high reset
//   push, push_data  : write request and data; ignored while full
//   pop, pop_data    : read request; pop_data always shows the head entry
//                      (only meaningful while !empty); ignored while empty
//   full, empty      : occupancy flags derived from level
//   level            : number of stored entries, 0..DEPTH
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             pop_data,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Full blocks a push even when a pop happens on the same edge (no bypass).
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;

   assign full     = (level == LW'(DEPTH));
   assign empty    = (level == '0);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   // Storage needs no reset: entries are only read after being written.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// 8N1 serial transmitter fed by a small byte FIFO.
// Parameters:
//   DIV   : clock cycles per serial bit, 2..255
//   DEPTH : FIFO entries, power of two, >= 2
// Ports:
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   in_valid   : writer presents in_data
//   in_data    : byte to transmit
//   in_ready   : FIFO can accept a byte (!full)
//   ser_tx     : registered serial line, idle high
//   busy       : a frame (START, DATA or STOP) is on the line
//   level      : FIFO occupancy
//   dbg_state  : current transmitter FSM state
//
// Handshake: a byte is transferred on every rising edge where in_valid and
// in_ready are both high. in_ready depends only on FIFO occupancy, never on
// in_valid; the writer may hold in_valid with stable data until accepted.
// -----------------------------------------------------------------------------
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DIV   = 6,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   input  logic [7:0]                   in_data,
   output logic                         in_ready,
   output logic                         ser_tx,
   output logic                         busy,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output tx_state_t                    dbg_state
);

   tx_state_t  state_q;
   tx_state_t  state_d;
   logic [7:0] divcnt_q;
   logic [7:0] divcnt_d;
   logic [2:0] bitidx_q;
   logic [2:0] bitidx_d;
   logic [7:0] shreg_q;
   logic [7:0] shreg_d;
   logic       ser_tx_q;
   logic       ser_tx_d;
   logic       pop;
   logic       full;
   logic       empty;
   logic [7:0] head;
   logic       bit_done;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (in_valid),
      .push_data (in_data),
      .pop       (pop),
      .pop_data  (head),
      .full      (full),
      .empty     (empty),
      .level     (level)
   );

   assign in_ready  = !full;
   assign ser_tx    = ser_tx_q;
   assign busy      = (state_q != IDLE);
   assign dbg_state = state_q;

   // Last cycle of the current bit period.
   assign bit_done  = (divcnt_q == 8'(DIV - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         divcnt_q <= '0;
         bitidx_q <= '0;
         shreg_q  <= '0;
         ser_tx_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         divcnt_q <= divcnt_d;
         bitidx_q <= bitidx_d;
         shreg_q  <= shreg_d;
         ser_tx_q <= ser_tx_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      divcnt_d = divcnt_q + 8'd1;
      bitidx_d = bitidx_q;
      shreg_d  = shreg_q;
      ser_tx_d = ser_tx_q;
      pop      = 1'b0;

      case (state_q)
         IDLE: begin
            divcnt_d = '0;
            ser_tx_d = 1'b1;
            if (!empty) begin
               pop      = 1'b1;
               shreg_d  = head;
               ser_tx_d = 1'b0;
               state_d  = START;
            end
         end

         START: begin
            if (bit_done) begin
               divcnt_d = '0;
               bitidx_d = '0;
               ser_tx_d = shreg_q[0];
               state_d  = DATA;
            end
         end

         DATA: begin
            if (bit_done) begin
               divcnt_d = '0;
               if (bitidx_q == 3'(UART_DATA_BITS - 1)) begin
                  ser_tx_d = 1'b1;
                  state_d  = STOP;
               end else begin
                  // Next bit is shreg[1]: the register shifts on this edge.
                  shreg_d  = shreg_q >> 1;
                  bitidx_d = bitidx_q + 3'd1;
                  ser_tx_d = shreg_q[1];
               end
            end
         end

         STOP: begin
            if (bit_done) begin
               divcnt_d = '0;
               if (!empty) begin
                  // Back-to-back frame: start bit follows the stop bit directly.
                  pop      = 1'b1;
                  shreg_d  = head;
                  ser_tx_d = 1'b0;
                  state_d  = START;
               end else begin
                  ser_tx_d = 1'b1;
                  state_d  = IDLE;
               end
            end
         end

         default: begin
            divcnt_d = '0;
            ser_tx_d = 1'b1;
            state_d  = IDLE;
         end
      endcase
   end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Serial transmitter with a small byte FIFO. It sits directly upstream of the serial-line decode monitor, driving `ser_tx` with 8N1 frames built from bytes pushed by the SoC-side writer. It provides the stimulus side of the "Hello World" cover flow: software bytes go in, a bit-accurate serial stream comes out.

## Interface
- `DIV`, default 6: clock cycles per serial bit; legal range 2..255.
- `DEPTH`, default 4: FIFO entries; must be a power of two, at least 2.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `in_valid` input 1: writer presents a byte.
- `in_data` input 8: byte to send.
- `in_ready` output 1: FIFO can accept a byte; equals `!full`. Reset value 1.
- `ser_tx` output 1: serial line, idle high, registered. Reset value 1.
- `busy` output 1: high while a frame is on the line (START, DATA or STOP). Reset value 0.
- `level` output $clog2(DEPTH+1): FIFO occupancy. Reset value 0.

## Operation
- Push: a byte is written on any edge where `in_valid && in_ready`. There is no bypass; when full, a same-cycle pop does not enable a push.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity. Frame length is 10*DIV cycles.
- FSM states:
  - IDLE: `ser_tx`=1. If `level`!=0, pop the head into `shreg`, drive `ser_tx`=0, go to START.
  - START: hold 0 for DIV cycles, then drive `shreg[0]` and go to DATA with `bitidx`=0.
  - DATA: each bit is held DIV cycles. Then `shreg` shifts right and `bitidx` increments. After bit 7, drive 1 and go to STOP.
  - STOP: hold 1 for DIV cycles. On expiry, if the FIFO is non-empty, pop and drive 0 directly (back-to-back START, no idle cycle). Otherwise go to IDLE.
- Counter `divcnt` runs 0..DIV-1 and wraps to 0 on every bit boundary. `bitidx` is 3 bits.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. `level` updates as +1 on push only, -1 on pop only, and is unchanged when push and pop happen together.
- `in_data` is sampled only on a push edge. Bytes already in the FIFO are unaffected by later writer activity.

## Timing
- A byte accepted at edge t into an empty FIFO with the FSM in IDLE is popped at edge t+1. `ser_tx` falls after edge t+1.
- The start bit falls at edge s. Data bit k is valid on edges s+(k+1)*DIV through s+(k+2)*DIV-1. The stop bit starts at edge s+9*DIV, and the line is free at s+10*DIV.
- `in_ready` deasserts the cycle after the push that makes `level`==DEPTH. It reasserts the cycle after the next pop.
- `reset` mid-frame immediately forces `ser_tx`=1, `busy`=0, `level`=0 and IDLE. The partial frame is abandoned and FIFO contents are discarded.
- After reset release, the line stays idle-high at least until the first push.

## Structure
- Shared package `uart_pkg`:
  - `tx_state_t` enum (IDLE, START, DATA, STOP).
  - Localparams `UART_DATA_BITS`=8 and `UART_FRAME_BITS`=10.
- Sub-module `sync_fifo`, parameterised by width and depth. Ports: push/pop/data, `full`, `empty`, `level`. The same asynchronous active-high reset applies.
- The top level holds the FSM, `divcnt`, `bitidx` and `shreg`.

## Test plan
- Reset only, 50 cycles: `ser_tx`=1, `in_ready`=1, `busy`=0 and `level`=0 throughout.
- Push 0x48 ("H") at edge t, DIV=6: `ser_tx`=0 for t+1..t+6, then bits 0,0,0,1,0,0,1,0 for 6 cycles each, then 1 for 6 cycles. `busy` falls at t+61.
- Push "Hello" on 5 consecutive edges, DEPTH=4:
  - All 5 are accepted (the first pops immediately). `level` peaks at 4 and `in_ready`=0.
  - 5 back-to-back frames totalling 300 cycles.
  - A decode monitor reports H,e,l,l,o with `bytecnt` 1..5.
- Hold `in_valid` with full FIFO: no push occurs until the STOP-to-START pop. Exactly one byte is accepted per frame, and no byte is lost or duplicated.
- Assert `reset` at cycle 20 of a frame with 3 bytes queued: `ser_tx`=1 asynchronously and `level`=0. After release, pushing 0x6F yields one clean frame.
- DIV=2 with "Hello World" (11 bytes): 11 frames of 20 cycles each. The decode monitor covers all 11 chars in order.
